// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding selects and load-use stall for a 5-stage pipe
module fwd_hazard_unit #(
    parameter int REGW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_rs_rd,
    input  logic            id_rt_rd,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_wr,
    input  logic            id_ld,
    input  logic            flush,
    output logic [1:0]      fwd_A,
    output logic [1:0]      fwd_B,
    output logic            stall
);

    logic            ex_v, ex_wr, ex_ld;
    logic [REGW-1:0] ex_rd;
    logic            mem_v, mem_wr, mem_ld;
    logic [REGW-1:0] mem_rd;

    logic ex_match_rs, ex_match_rt, mem_match_rs, mem_match_rt;
    logic hazard, load_ex;
    logic [1:0] fwd_a_nxt, fwd_b_nxt;

    // A source only matches when the instruction actually reads it through the ALU port.
    assign ex_match_rs  = ex_v  & ex_wr  & (ex_rd  == id_rs) & id_rs_rd;
    assign ex_match_rt  = ex_v  & ex_wr  & (ex_rd  == id_rt) & id_rt_rd;
    assign mem_match_rs = mem_v & mem_wr & (mem_rd == id_rs) & id_rs_rd;
    assign mem_match_rt = mem_v & mem_wr & (mem_rd == id_rt) & id_rt_rd;

    assign hazard  = ex_ld & (ex_match_rs | ex_match_rt);
    assign stall   = id_valid & hazard & ~flush;
    assign load_ex = id_valid & ~stall & ~flush;

    // The younger producer in EX takes priority over the one in MEM.
    assign fwd_a_nxt = load_ex ? {ex_match_rs, mem_match_rs & ~ex_match_rs} : 2'b00;
    assign fwd_b_nxt = load_ex ? {ex_match_rt, mem_match_rt & ~ex_match_rt} : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_v   <= 1'b0;
            ex_wr  <= 1'b0;
            ex_ld  <= 1'b0;
            ex_rd  <= '0;
            mem_v  <= 1'b0;
            mem_wr <= 1'b0;
            mem_ld <= 1'b0;
            mem_rd <= '0;
            fwd_A  <= 2'b00;
            fwd_B  <= 2'b00;
        end else begin
            mem_v  <= ex_v;
            mem_wr <= ex_wr;
            mem_ld <= ex_ld;
            mem_rd <= ex_rd;
            ex_v   <= load_ex;
            ex_wr  <= load_ex & id_wr;
            ex_ld  <= load_ex & id_ld;
            ex_rd  <= load_ex ? id_rd : '0;
            fwd_A  <= fwd_a_nxt;
            fwd_B  <= fwd_b_nxt;
        end
    end

    // The MEM-slot load flag is tracked for completeness; a load there forwards like any producer.
    logic unused_mem_ld;
    assign unused_mem_ld = mem_ld;

endmodule
